// File: rtl/tx_uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter:
// FSM states, parity/data-bit encodings and frame-format helper functions.
package tx_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [1:0] DB_5 = 2'd0;
    localparam logic [1:0] DB_6 = 2'd1;
    localparam logic [1:0] DB_7 = 2'd2;
    localparam logic [1:0] DB_8 = 2'd3;

    function automatic logic [3:0] data_bits_n(input logic [1:0] cfg);
        logic [3:0] n;
        case (cfg)
            DB_5:    n = 4'd5;
            DB_6:    n = 4'd6;
            DB_7:    n = 4'd7;
            DB_8:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Parity over only the used data bits; odd parity is the inverted XOR.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] cfg,
                                         input logic       odd);
        logic [7:0] mask;
        case (cfg)
            DB_5:    mask = 8'h1F;
            DB_6:    mask = 8'h3F;
            DB_7:    mask = 8'h7F;
            DB_8:    mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return (^(data & mask)) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with level count; push is ignored when full and pop when empty.
module uart_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == {LW{1'b0}});
    assign level_o   = level_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and level next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer/level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tx_uart_fifo.sv
// Configurable UART transmitter (5-8 data bits, none/even/odd parity, 1-2 stop bits)
// fed by an internal FIFO so queued frames go out back-to-back.
module tx_uart_fifo
    import tx_uart_pkg::*;
#(
    parameter  int DIV_W      = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             tx_pin,
    output logic             busy,
    output logic             tx_done,
    output logic [LVL_W-1:0] fifo_level
);

    tx_state_e        state_q,    state_d;
    logic [7:0]       shift_q,    shift_d;
    logic             par_bit_q,  par_bit_d;
    logic             par_en_q,   par_en_d;
    logic             stop2_q,    stop2_d;
    logic [2:0]       last_idx_q, last_idx_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [DIV_W-1:0] timer_q,    timer_d;
    logic             tx_pin_q,   tx_pin_d;
    logic             tx_done_q,  tx_done_d;

    logic             start_frame_s;
    logic             timer_zero_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_data_s;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (start_frame_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

    assign timer_zero_s = (timer_q == {DIV_W{1'b0}});
    assign in_ready     = !fifo_full_s;
    assign tx_pin       = tx_pin_q;
    assign tx_done      = tx_done_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty_s;

    // Frame sequencer: tx_pin_d is the line level for the cycle after this edge.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        par_bit_d     = par_bit_q;
        par_en_d      = par_en_q;
        stop2_d       = stop2_q;
        last_idx_d    = last_idx_q;
        bit_idx_d     = bit_idx_q;
        stop_idx_d    = stop_idx_q;
        div_d         = div_q;
        timer_d       = timer_zero_s ? div_q : (timer_q - DIV_W'(1));
        tx_pin_d      = tx_pin_q;
        tx_done_d     = 1'b0;
        start_frame_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d       = timer_q;
                tx_pin_d      = 1'b1;
                start_frame_s = !fifo_empty_s;
            end
            ST_START: begin
                if (timer_zero_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_pin_d  = shift_q[0];
                end else begin
                    state_d   = ST_START;
                end
            end
            ST_DATA: begin
                if (timer_zero_s && (bit_idx_q == last_idx_q)) begin
                    state_d    = par_en_q ? ST_PARITY : ST_STOP;
                    tx_pin_d   = par_en_q ? par_bit_q : 1'b1;
                    stop_idx_d = 1'b0;
                end else if (timer_zero_s) begin
                    bit_idx_d  = bit_idx_q + 3'd1;
                    shift_d    = {1'b0, shift_q[7:1]};
                    tx_pin_d   = shift_q[1];
                end else begin
                    state_d    = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (timer_zero_s) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_pin_d   = 1'b1;
                end else begin
                    state_d    = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (timer_zero_s && stop2_q && !stop_idx_q) begin
                    stop_idx_d = 1'b1;
                end else if (timer_zero_s) begin
                    // Final stop period ends: chain straight into the next frame if one is queued.
                    tx_done_d     = 1'b1;
                    state_d       = ST_IDLE;
                    tx_pin_d      = 1'b1;
                    start_frame_s = !fifo_empty_s;
                end else begin
                    state_d       = ST_STOP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_pin_d = 1'b1;
                timer_d  = {DIV_W{1'b0}};
            end
        endcase

        if (start_frame_s) begin
            state_d    = ST_START;
            shift_d    = fifo_data_s;
            par_bit_d  = calc_parity(fifo_data_s, cfg_data_bits, (cfg_parity == PAR_ODD));
            par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            stop2_d    = cfg_stop2;
            last_idx_d = 3'(data_bits_n(cfg_data_bits) - 4'd1);
            div_d      = baud_div;
            timer_d    = baud_div;
            tx_pin_d   = 1'b0;
        end else begin
            shift_d    = shift_d;
        end
    end

    // FSM, shadow configuration and output registers; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            last_idx_q <= 3'd7;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            div_q      <= {DIV_W{1'b0}};
            timer_q    <= {DIV_W{1'b0}};
            tx_pin_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            last_idx_q <= last_idx_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            div_q      <= div_d;
            timer_q    <= timer_d;
            tx_pin_q   <= tx_pin_d;
            tx_done_q  <= tx_done_d;
        end
    end

endmodule

// File: doc/tx_uart_fifo.md
Name: tx_uart_fifo

Overview:
Parametrised successor to the project's fixed 8N1 serial transmitter. Runtime-configurable frame formats:
- 5–8 data bits
- parity none/even/odd
- 1 or 2 stop bits

An internal FIFO decouples the producer, so frames go out back-to-back with no idle gap. It sits between any byte producer (CPU bus bridge, debug streamer) and the TX pad.

Parameters:
DIV_W, 16, width of baud_div counter.
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived, not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
baud_div  in  DIV_W  bit period minus one, in clk cycles
cfg_data_bits  in  2  0=5, 1=6, 2=7, 3=8 data bits
cfg_parity  in  2  0=none, 1=even, 2=odd, 3=none (reserved)
cfg_stop2  in  1  0=one stop bit, 1=two stop bits
in_valid  in  1  producer has byte on in_data
in_data  in  8  byte to send; unused upper bits ignored
in_ready  out  1  FIFO can accept (=!full)
tx_pin  out  1  serial output, idle high
busy  out  1  frame in progress or FIFO non-empty
tx_done  out  1  one-cycle pulse at end of each frame
fifo_level  out  LVL_W  bytes currently queued (excludes the frame being sent)

Behaviour:
Reset (async, rst=0):
- tx_pin=1, busy=0, tx_done=0, in_ready=1, fifo_level=0.
- FIFO emptied, FSM to IDLE.
- A frame in progress is aborted immediately; tx_pin goes high without waiting for a clock.

Push:
- Push happens on a clk edge with in_valid && in_ready.
- in_ready is low when the FIFO is full; no push occurs when full.

FSM states: IDLE, START, DATA, PARITY, STOP.

IDLE:
- On an edge where the FIFO is non-empty: pop head, latch data, latch all cfg_* and baud_div into shadow registers, load bit_timer=baud_div, enter START.
- tx_pin=0 from that edge.
- Config changes mid-frame do not affect the current frame.

Bit timing:
- Every bit holds tx_pin for exactly baud_div+1 clk cycles. baud_div=0 gives 1 cycle per bit.
- bit_timer counts down. Advance to the next bit on the edge where bit_timer==0, reloading the latched baud_div.

DATA:
- LSB first, n = 5..8 bits per the latched cfg_data_bits.
- Then go to PARITY if parity is enabled, else STOP.

PARITY:
- even: XOR of the n used data bits.
- odd: its inverse.
- Bits above n are excluded.

STOP:
- tx_pin=1 for 1 or 2 bit periods.
- At the end of the final stop period, pulse tx_done for exactly one cycle.
- If the FIFO is non-empty at that edge, pop and enter START on the same edge (zero idle cycles). Otherwise go to IDLE.

Latency and frame length:
- Push into an empty, idle block at edge k → pop at edge k+1 → tx_pin low after edge k+1.
- Frame length = (1 + n + p + s)·(baud_div+1) cycles, where p∈{0,1} and s∈{1,2}.

FIFO and status:
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop on the same edge: level unchanged.
- busy = (state != IDLE) || fifo_level != 0.

Robustness:
- An illegal state encoding returns to IDLE with tx_pin=1.

Decomposition:
Package tx_uart_pkg holds:
- FSM state enum.
- Parity encodings PAR_NONE/PAR_EVEN/PAR_ODD.
- Data-bit encodings.
- Helper function returning n from cfg_data_bits.

Sub-module uart_sync_fifo (parameters DEPTH, WIDTH=8): push/pop/full/empty/level with async active-low reset. The top holds the FSM, shift register, bit timer and parity.

Test Plan:
1. Reset values: assert rst=0 mid-frame (8N1, 0xA5, baud_div=9, rst during bit 3) → tx_pin=1 immediately; in_ready=1; fifo_level=0; busy=0; no tx_done pulse.
2. 8N1, baud_div=3, push 0x55 → start low 4 cycles, bits 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles, tx_done at cycle 40 after the start edge.
3. 7E2, baud_div=1, push 0x41 → 7 data bits 1000001, parity 0, two stop bits; frame = 11×2 = 22 cycles.
4. 5O1, baud_div=0, push 0xFF → data 11111 (upper bits ignored), parity 0, frame 8 cycles; change cfg_data_bits mid-frame → frame unchanged.
5. FIFO_DEPTH=4, baud_div=7: push 6 bytes back-to-back with in_valid held → first pops immediately, in_ready drops when fifo_level=4, remaining byte accepted after the next pop. All 6 frames are contiguous (stop→start with no extra high cycle); 6 tx_done pulses.
6. Push on the same edge as a stop-end pop with FIFO at level 1 → level stays 1; next frame starts on that edge; data order preserved.
